// File: rtl/fas_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_t / IDLE, RUN, DONE : controller FSM encoding
//   OP_ADD / OP_SUB           : values of the captured operation select
package fas_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fas.sv
// One-bit full adder/subtractor cell.
//   a_i, b_i, cin_i : operand bits and incoming carry/borrow
//   a_ns_i          : 0 = a+b+cin, 1 = a-b-cin
//   s_o             : sum/difference bit
//   cout_o          : carry (add) or borrow (subtract)
module fas (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    input  logic a_ns_i,
    output logic s_o,
    output logic cout_o
);

    logic a_x;

    // Borrow is the carry majority with A inverted.
    assign a_x    = a_i ^ a_ns_i;
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_x & b_i) | (a_x & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/fas_serial_ctrl.sv
// Bit-serial add/subtract sequencer around a single fas cell, LSB first.
//   clk, rst_n         : clock and asynchronous active-low reset
//   start, op_sub      : request and operation (0 add, 1 subtract), sampled while ready
//   a_in, b_in         : operands captured with start
//   abort              : cancels a running operation, no done pulse
//   ready, busy, done  : handshake (done is a one-cycle pulse)
//   result, cout_flag, ovf : registered result, final carry/borrow, signed overflow
module fas_serial_ctrl
    import fas_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_flag,
    output logic             ovf
);

    localparam int unsigned       CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               op_q, op_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               cell_s;
    logic               cell_cout;
    logic               capture;
    logic               ovf_last;

    fas u_fas (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .a_ns_i (op_q),
        .s_o    (cell_s),
        .cout_o (cell_cout)
    );

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign cout_flag = cout_q;
    assign ovf       = ovf_q;

    assign capture = start && ready;

    // Overflow from the captured operand MSBs and the MSB produced on the last bit.
    always_comb begin
        ovf_last = 1'b0;
        unique case (op_q)
            OP_ADD: ovf_last = (a_msb_q == b_msb_q) && (cell_s != a_msb_q);
            OP_SUB: ovf_last = (a_msb_q != b_msb_q) && (cell_s != a_msb_q);
            default: ovf_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Sum bits enter A's MSB as A drains, so A holds the result after WIDTH shifts.
                    a_sh_d  = {cell_s, a_sh_q[WIDTH-1:1]};
                    b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                    carry_d = cell_cout;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DONE;
                        result_d = {cell_s, a_sh_q[WIDTH-1:1]};
                        cout_d   = cell_cout;
                        ovf_d    = ovf_last;
                    end
                end
            end
            DONE:    state_d = IDLE;
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d = RUN;
            a_sh_d  = a_in;
            b_sh_d  = b_in;
            op_d    = op_sub;
            a_msb_d = a_in[WIDTH-1];
            b_msb_d = b_in[WIDTH-1];
            carry_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fas_serial_ctrl.sv
// Directed self-checking bench for fas_serial_ctrl at WIDTH = 8.
module tb_fas_serial_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout_flag;
    logic             ovf;

    int vec_cnt;
    int err_cnt;

    fas_serial_ctrl #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_sub    (op_sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .abort     (abort),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout_flag (cout_flag),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen or the budget runs out; returns edges taken.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic ec,
                          input logic eo);
        int n;
        start  = 1'b1;
        op_sub = op;
        a_in   = a;
        b_in   = b;
        tick();
        start = 1'b0;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_ready_run"}, 32'(ready), 32'd0);
        wait_done(n);
        check_val({tag, "_latency"}, 32'(n), 32'd8);
        check_val({tag, "_ready_done"}, 32'(ready), 32'd1);
        check_val({tag, "_result"}, 32'(result), 32'(er));
        check_val({tag, "_cout"}, 32'(cout_flag), 32'(ec));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        int n;
        int seen;
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op_sub  = 1'b0;
        a_in    = '0;
        b_in    = '0;
        abort   = 1'b0;

        #12;
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_result", 32'(result), 32'd0);
        check_val("rst_cout", 32'(cout_flag), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("add5a33", 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1);
        tick();
        check_val("add5a33_pulse", 32'(done), 32'd0);
        check_val("add5a33_hold", 32'(result), 32'h8D);

        run_op("addff01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        tick();
        run_op("sub1020", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        tick();
        run_op("sub8001", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        tick();

        // start pulsed mid-RUN must be ignored
        start = 1'b1; op_sub = 1'b0; a_in = 8'h5A; b_in = 8'h33;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; op_sub = 1'b1; a_in = 8'h11; b_in = 8'h22;
        tick();
        start = 1'b0;
        check_val("ign_ready", 32'(ready), 32'd0);
        check_val("ign_keep_old", 32'(result), 32'h7F);
        wait_done(n);
        check_val("ign_latency", 32'(n), 32'd5);
        check_val("ign_result", 32'(result), 32'h8D);

        // back-to-back: start held in the DONE cycle
        start = 1'b1; op_sub = 1'b1; a_in = 8'h10; b_in = 8'h20;
        tick();
        start = 1'b0;
        check_val("b2b_done_low", 32'(done), 32'd0);
        check_val("b2b_busy", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check_val("b2b_interval", 32'(n), 32'd9);
        check_val("b2b_result", 32'(result), 32'hF0);
        check_val("b2b_cout", 32'(cout_flag), 32'd1);
        tick();

        // abort sampled on the edge that would process bit 3
        start = 1'b1; op_sub = 1'b0; a_in = 8'h0F; b_in = 8'h01;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_ready", 32'(ready), 32'd1);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_result", 32'(result), 32'hF0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen++;
            tick();
        end
        check_val("abort_no_done", 32'(seen), 32'd0);
        run_op("add0f01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        tick();

        // asynchronous reset in the middle of RUN
        start = 1'b1; op_sub = 1'b0; a_in = 8'h5A; b_in = 8'h33;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_ready", 32'(ready), 32'd1);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_result", 32'(result), 32'd0);
        #9 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen++;
        end
        check_val("arst_no_done", 32'(seen), 32'd0);
        check_val("arst_idle", 32'(ready), 32'd1);
        run_op("post_rst", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
